pc_branch_sequencer: RTL and testbench
======================================

// Module: pc_branch_sequencer
// PURPOSE
//  Program-counter and fetch/branch sequencer for the 12-bit-register CPU.
//  - Fetches instructions over a req/ack instruction-memory handshake.
//  - Presents each fetched instruction to decode.
//  - Consumes the 8-bit comparator's not-equal flag (cmp_ne) to resolve BEQ/BNE.
//  - Updates the PC to the branch target or to PC+1.
// PARAMETERS
//  ADDR_W      8       PC / instruction-memory address width
//  INSTR_W     12      instruction width
//  RESET_PC    8'h00   PC value after reset
//  HALT_INSTR  12'hFFF instruction word that halts the sequencer
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous active-low reset
//  run          in   1        enable: start/continue fetching
//  imem_req     out  1        fetch request, high throughout FETCH
//  imem_addr    out  ADDR_W   fetch address (= pc)
//  imem_ack     in   1        imem_rdata valid this cycle
//  imem_rdata   in   INSTR_W  fetched instruction
//  instr        out  INSTR_W  latched instruction for decode
//  instr_valid  out  1        1-cycle pulse: instr is new (high during EXEC)
//  br_type      in   2        from decode, valid in EXEC: 00 none, 01 BEQ, 10 BNE, 11 JMP
//  br_target    in   ADDR_W   branch target, valid in EXEC
//  cmp_ne       in   1        comparator output: 1 = operands differ; valid in EXEC
//  pc           out  ADDR_W   current program counter
//  taken        out  1        1-cycle pulse, the cycle after a taken branch resolves
//  halted       out  1        high while in HALTED
// BEHAVIOUR
//  - Reset (async, any state):
//    - state=IDLE, pc=RESET_PC; instr, instr_valid, taken, halted, imem_req all 0.
//    - imem_req falls immediately, without waiting for a clock edge.
//  - FSM states: IDLE, FETCH, EXEC, HALTED. All transitions on rising clk.
//  - IDLE:   run=1 -> FETCH; otherwise stay.
//  - FETCH:
//    - imem_req=1; imem_addr=pc, held stable until ack.
//    - imem_ack=1 -> latch imem_rdata into instr, go to EXEC.
//    - run dropping in FETCH does not abort the fetch; completes on ack.
//  - EXEC (exactly 1 cycle, instr_valid=1):
//    - instr==HALT_INSTR -> HALTED; pc unchanged, br inputs ignored.
//    - else taken_c = (br_type==01 & ~cmp_ne) | (br_type==10 & cmp_ne) | (br_type==11).
//    - pc <= taken_c ? br_target : pc+1; increment wraps mod 2^ADDR_W (8'hFF -> 8'h00).
//    - taken <= taken_c; taken is 0 in every other cycle.
//    - Next state: FETCH if run=1, else IDLE.
//  - HALTED: halted=1, imem_req=0; run=0 -> IDLE; run=1 -> stay.
//  - imem_ack outside FETCH: ignored; no state or register change.
//  - Branch to self (br_target==pc) is legal; refetches the same address.
//  - Latency: zero-wait memory (ack in first FETCH cycle) = 2 cycles/instruction.
//    Each wait cycle adds 1.
//  - First request appears the cycle after run is sampled high in IDLE.
//  - imem_req, instr_valid, halted decode from the registered state only (glitch-free).
// TESTING
//  1 Reset: rst_n=0 mid-FETCH -> imem_req drops with no clock; pc=00, all outputs 0.
//    Release, run=1 -> imem_req=1, imem_addr=00 next cycle.
//  2 Sequential: ack every FETCH, instr=12'h123, br_type=00 -> pc 00,01,02 every 2 cycles.
//    instr_valid pulses once per instr.
//  3 BNE: br_type=10, br_target=40, cmp_ne=1 -> pc=40, taken=1 one cycle.
//    Same with cmp_ne=0 -> pc=pc+1, taken=0.
//  4 BEQ/JMP: br_type=01, cmp_ne=0, br_target=10 -> pc=10.
//    br_type=11, cmp_ne=1, br_target=33 -> pc=33.
//  5 Wait/wrap: ack delayed 3 cycles -> req and addr held stable throughout.
//    pc=FF, non-branch -> pc=00.
//  6 Halt: instr=12'hFFF -> halted=1, pc unchanged, no further req.
//    run=0 -> IDLE; run=1 -> fetch resumes at same pc.

Source files
------------

// File: rtl/pc_branch_sequencer.sv
// -----------------------------------------------------------------------------
// pc_branch_sequencer
//
// Program-counter and fetch/branch sequencer for the 12-bit-register CPU.
// It fetches one instruction at a time over a req/ack instruction-memory
// handshake. It presents the fetched word to decode for exactly one EXEC
// cycle, then resolves BEQ/BNE/JMP using the comparator's not-equal flag and
// the decode-supplied target. Finally it moves the PC to the target or to PC+1.
//
// Handshake (imem):
//   imem_req is high for every cycle the sequencer sits in FETCH.
//   imem_addr (= pc) is constant for that whole time.
//   The transfer completes on the first rising edge where imem_ack is high.
//   imem_rdata is captured on that edge.
//   imem_ack seen in any other state is ignored.
//
// Ports:
//   clk          in   1        rising-edge clock
//   rst_n        in   1        asynchronous active-low reset
//   run          in   1        start/continue fetching
//   imem_req     out  1        fetch request, high throughout FETCH
//   imem_addr    out  ADDR_W   fetch address (= pc)
//   imem_ack     in   1        imem_rdata valid this cycle
//   imem_rdata   in   INSTR_W  fetched instruction
//   instr        out  INSTR_W  latched instruction for decode
//   instr_valid  out  1        high during EXEC (one cycle per instruction)
//   br_type      in   2        00 none, 01 BEQ, 10 BNE, 11 JMP (valid in EXEC)
//   br_target    in   ADDR_W   branch target (valid in EXEC)
//   cmp_ne       in   1        1 = compared operands differ (valid in EXEC)
//   pc           out  ADDR_W   current program counter
//   taken        out  1        pulse in the cycle after a taken branch resolves
//   halted       out  1        high while in HALTED
//   dbg_state    out  2        registered FSM state, for observation only
// -----------------------------------------------------------------------------
module pc_branch_sequencer #(
  parameter int                  ADDR_W     = 8,
  parameter int                  INSTR_W    = 12,
  parameter logic [ADDR_W-1:0]   RESET_PC   = '0,
  parameter logic [INSTR_W-1:0]  HALT_INSTR = '1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic [1:0]         br_type,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic               cmp_ne,
  output logic [ADDR_W-1:0]  pc,
  output logic               taken,
  output logic               halted,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_EXEC   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_JMP  = 2'b11;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                taken_q, taken_d;
  logic                branch_c;
  logic                is_halt;

  // Branch condition from the decode/comparator inputs. It is only consumed
  // in EXEC, so it may be evaluated unconditionally.
  always_comb begin
    branch_c = 1'b0;
    case (br_type)
      BR_NONE: branch_c = 1'b0;
      BR_BEQ:  branch_c = ~cmp_ne;
      BR_BNE:  branch_c = cmp_ne;
      BR_JMP:  branch_c = 1'b1;
      default: branch_c = 1'b0;
    endcase
  end

  assign is_halt = (instr_q == HALT_INSTR);

  // Next-state and next-register logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    taken_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        // run is deliberately not looked at here: an issued request always
        // completes so the memory never sees a request withdrawn mid-flight.
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (is_halt) begin
          // The halt word ignores any branch inputs and leaves pc in place so
          // that a later restart refetches the same address.
          state_d = S_HALTED;
        end else begin
          pc_d    = branch_c ? br_target : (pc_q + PC_ONE);
          taken_d = branch_c;
          state_d = run ? S_FETCH : S_IDLE;
        end
      end

      S_HALTED: begin
        if (!run) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      taken_q <= taken_d;
    end
  end

  // Status outputs decode directly from the registered state. This makes them
  // glitch-free. Because reset clears the state asynchronously, imem_req also
  // drops the moment rst_n falls.
  assign imem_req    = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_EXEC);
  assign halted      = (state_q == S_HALTED);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign taken       = taken_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_branch_sequencer
//
// Acts as instruction memory and decode for pc_branch_sequencer.
// It runs directed cases and then randomized instruction streams.
// The reference model works per instruction: it applies the branch/halt rules
// to a modelled pc and queues the pc expected after each EXEC.
// Inputs are driven on the falling edge and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_pc_branch_sequencer;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        run;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [11:0] imem_rdata;
  logic [11:0] instr;
  logic        instr_valid;
  logic [1:0]  br_type;
  logic [7:0]  br_target;
  logic        cmp_ne;
  logic [7:0]  pc;
  logic        taken;
  logic        halted;
  logic [1:0]  dbg_state;

  pc_branch_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .br_type     (br_type),
    .br_target   (br_target),
    .cmp_ne      (cmp_ne),
    .pc          (pc),
    .taken       (taken),
    .halted      (halted),
    .dbg_state   (dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  m_pc;
  logic [11:0] m_instr;
  bit          m_halt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- driver tasks
  // Precondition: at a falling edge with the DUT requesting a fetch.
  // Runs one full instruction and checks the pc and taken that follow it.
  task automatic step_instr(input logic [11:0] word, input int waits,
                            input logic [1:0] bt, input logic [7:0] tgt,
                            input logic ne, input logic run_next,
                            input bit drop_run);
    logic [7:0] exp_pc;
    bit         exp_taken;
    for (int w = 0; w < waits; w++) begin
      check("req_wait", imem_req, 1'b1);
      check("addr_wait", imem_addr, m_pc);
      imem_ack   = 1'b0;
      imem_rdata = 12'($urandom);
      if (drop_run) run = 1'b0;
      @(negedge clk);
    end
    check("req", imem_req, 1'b1);
    check("addr", imem_addr, m_pc);
    imem_ack   = 1'b1;
    imem_rdata = word;
    br_type    = bt;
    br_target  = tgt;
    cmp_ne     = ne;
    run        = run_next;
    @(negedge clk);
    // EXEC cycle
    imem_ack   = 1'b0;
    imem_rdata = 12'($urandom);
    check("instr_valid", instr_valid, 1'b1);
    check("instr", instr, word);
    check("req_exec", imem_req, 1'b0);
    check("taken_exec", taken, 1'b0);
    m_instr = word;
    if (word == 12'hFFF) begin
      exp_pc    = m_pc;
      exp_taken = 1'b0;
      m_halt    = 1'b1;
    end else begin
      exp_taken = (bt == 2'b01 && !ne) || (bt == 2'b10 && ne) || (bt == 2'b11);
      exp_pc    = exp_taken ? tgt : 8'((int'(m_pc) + 1) % 256);
    end
    exp_q.push_back(exp_pc);
    @(negedge clk);
    check("pc", pc, exp_q.pop_front());
    check("taken", taken, exp_taken);
    check("instr_valid_off", instr_valid, 1'b0);
    check("halted", halted, m_halt);
    check("req_after", imem_req, (!m_halt && run_next));
    m_pc = exp_pc;
  endtask

  // Precondition: at a falling edge with the DUT in IDLE or HALTED.
  // Brings the DUT back to a fetching state.
  task automatic resume();
    if (m_halt) begin
      run = 1'b1;
      @(negedge clk);
      check("halt_hold", halted, 1'b1);
      check("halt_noreq", imem_req, 1'b0);
      run = 1'b0;
      @(negedge clk);
      check("halt_exit", halted, 1'b0);
      m_halt = 1'b0;
    end
    // A stray ack while idle must change nothing.
    imem_ack   = 1'b1;
    imem_rdata = 12'($urandom);
    @(negedge clk);
    imem_ack = 1'b0;
    check("idle_noreq", imem_req, 1'b0);
    check("idle_pc", pc, m_pc);
    check("idle_instr", instr, m_instr);
    run = 1'b1;
    @(negedge clk);
    check("resume_req", imem_req, 1'b1);
    check("resume_addr", imem_addr, m_pc);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst_n      = 1'b0;
    run        = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    br_type    = '0;
    br_target  = '0;
    cmp_ne     = 1'b0;
    m_pc       = 8'h00;
    m_instr    = 12'h000;
    m_halt     = 1'b0;
    @(negedge clk);
    check("rst_req", imem_req, 1'b0);
    check("rst_pc", pc, 8'h00);
    check("rst_halted", halted, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_wait_req", imem_req, 1'b0);
    run = 1'b1;
    @(negedge clk);
    check("first_req", imem_req, 1'b1);
    check("first_addr", imem_addr, 8'h00);

    // Sequential non-branch instructions
    for (int i = 0; i < 3; i++) step_instr(12'h123, 0, 2'b00, 8'hAA, 1'b0, 1'b1, 1'b0);
    // BNE taken / not taken
    step_instr(12'h200, 0, 2'b10, 8'h40, 1'b1, 1'b1, 1'b0);
    step_instr(12'h201, 0, 2'b10, 8'h77, 1'b0, 1'b1, 1'b0);
    // BEQ taken and not taken, JMP
    step_instr(12'h300, 0, 2'b01, 8'h10, 1'b0, 1'b1, 1'b0);
    step_instr(12'h301, 0, 2'b01, 8'h66, 1'b1, 1'b1, 1'b0);
    step_instr(12'h400, 0, 2'b11, 8'h33, 1'b1, 1'b1, 1'b0);
    // Wait states with run dropped during the fetch
    step_instr(12'h123, 3, 2'b00, 8'h00, 1'b0, 1'b1, 1'b1);
    // Wrap FF -> 00
    step_instr(12'h400, 0, 2'b11, 8'hFF, 1'b0, 1'b1, 1'b0);
    step_instr(12'h123, 2, 2'b00, 8'h12, 1'b1, 1'b1, 1'b0);
    // Branch to self
    step_instr(12'h400, 0, 2'b11, m_pc, 1'b0, 1'b1, 1'b0);
    // Halt with branch inputs that would otherwise be taken
    step_instr(12'h400, 0, 2'b11, 8'h5A, 1'b0, 1'b1, 1'b0);
    step_instr(12'hFFF, 1, 2'b11, 8'h99, 1'b1, 1'b1, 1'b0);
    resume();
    // Stop after an instruction, then restart
    step_instr(12'h123, 0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
    resume();

    // Asynchronous reset in the middle of a fetch
    step_instr(12'h400, 0, 2'b11, 8'h55, 1'b0, 1'b1, 1'b0);
    check("pre_rst_req", imem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_req_drop", imem_req, 1'b0);
    check("async_pc", pc, 8'h00);
    check("async_instr", instr, 12'h000);
    check("async_valid", instr_valid, 1'b0);
    check("async_taken", taken, 1'b0);
    check("async_halted", halted, 1'b0);
    m_pc = 8'h00;
    m_instr = 12'h000;
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;
    @(negedge clk);
    check("post_rst_req", imem_req, 1'b1);
    check("post_rst_addr", imem_addr, 8'h00);

    // Randomized instruction stream
    for (int i = 0; i < 200; i++) begin
      logic [11:0] word;
      logic        rn;
      word = ($urandom_range(0, 15) == 0) ? 12'hFFF : 12'($urandom);
      rn   = ($urandom_range(0, 7) != 0);
      step_instr(word, $urandom_range(0, 3), 2'($urandom_range(0, 3)),
                 8'($urandom), 1'($urandom_range(0, 1)), rn,
                 ($urandom_range(0, 4) == 0));
      if (m_halt || !rn) resume();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
